// File: rtl/tx_anc_gen_if.sv
// AXI-Stream IQ sample channel between the ANC pilot generator and the radio TX path.
interface tx_anc_gen_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [DATA_WIDTH-1:0] itx;
  logic [DATA_WIDTH-1:0] qtx;

  modport master (output tvalid, tlast, itx, qtx, input tready);
  modport slave  (input tvalid, tlast, itx, qtx, output tready);
endinterface

// File: rtl/tx_anc_gen.sv
// ANC pilot tone/burst generator: phase accumulator -> quarter-wave ROM -> amplitude scale,
// emitted as NSIG-sample AXI-Stream bursts. State | meaning: IDLE wait start, RUN issue samples, GAP inter-burst idle.
module tx_anc_gen #(
  parameter int                     DATA_WIDTH  = 16,
  parameter int                     PHASE_WIDTH = 24,
  parameter int                     PPM_WIDTH   = 32,
  parameter int                     LUT_BITS    = 10,
  parameter int                     NSIG        = 32768,
  parameter int                     GAP         = 0,
  parameter logic [PHASE_WIDTH-1:0] DPH_INC     = PHASE_WIDTH'(2048),
  parameter logic [PHASE_WIDTH-1:0] START_PH    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   srst_i,
  input  logic                   start_i,
  input  logic                   continuous_i,
  input  logic [PPM_WIDTH-1:0]   ppm_val_i,
  input  logic [DATA_WIDTH-1:0]  scale_val_i,
  tx_anc_gen_if.master           m_axis,
  output logic                   busy_o,
  output logic [PHASE_WIDTH-1:0] ph_o,
  output logic [PHASE_WIDTH-1:0] sig_n_o
);
  localparam int AW    = LUT_BITS + 2;
  localparam int LUT_N = 1 << LUT_BITS;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [LUT_BITS:0]       LUT_N_V   = {1'b1, {LUT_BITS{1'b0}}};
  localparam logic [DATA_WIDTH-1:0]   SCALE_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [PHASE_WIDTH-1:0]  LAST_CNT  = PHASE_WIDTH'(NSIG - 1);
  localparam longint ONE_Q30 = longint'(1) << 30;
  localparam longint PI_Q30  = 64'sd3373259426;
  localparam longint AMP     = (longint'(1) << (DATA_WIDTH - 1)) - 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;

  // Elaboration-time sine in Q30 fixed point (Taylor to x^15) so the ROM needs no init file.
  function automatic logic [DATA_WIDTH-1:0] sin_entry(input int j);
    longint x, term, sum, v;
    x = (PI_Q30 * longint'(j) + (longint'(1) << LUT_BITS)) >>> (LUT_BITS + 1);
    term = x;
    sum  = x;
    for (int k = 1; k < 8; k++) begin
      term = -((((term * x) / ONE_Q30) * x) / ONE_Q30) / longint'(2 * k * (2 * k + 1));
      sum  = sum + term;
    end
    v = (sum * AMP + ONE_Q30 / 2) / ONE_Q30;
    if (v > AMP) v = AMP;
    if (v < 0) v = 0;
    return DATA_WIDTH'(v);
  endfunction

  logic [DATA_WIDTH-1:0] rom [0:LUT_N];
  for (genvar j = 0; j <= LUT_N; j++) begin : g_rom
    assign rom[j] = sin_entry(j);
  end

  function automatic logic signed [DATA_WIDTH-1:0] lookup(input logic [AW-1:0] p);
    logic [LUT_BITS:0]     a, idx;
    logic [DATA_WIDTH-1:0] l;
    a   = {1'b0, p[LUT_BITS-1:0]};
    idx = p[LUT_BITS] ? (LUT_N_V - a) : a;
    l   = rom[idx];
    return p[AW-1] ? -$signed(l) : $signed(l);
  endfunction

  // Operands widened first so the full product survives before the floor shift.
  function automatic logic [DATA_WIDTH-1:0] scale_mul(input logic signed [DATA_WIDTH-1:0] v,
                                                      input logic [DATA_WIDTH-1:0] s);
    logic signed [2*DATA_WIDTH:0] prod;
    prod = (2*DATA_WIDTH+1)'(v) * $signed({{(DATA_WIDTH+1){1'b0}}, s});
    return DATA_WIDTH'(prod >>> (DATA_WIDTH - 1));
  endfunction

  state_t                  state_q;
  logic [PHASE_WIDTH-1:0]  phase_q, inc_q, count_q;
  logic [DATA_WIDTH-1:0]   scale_q;
  logic [GAP_W-1:0]        gap_q;
  logic                    v1_q, l1_q, v2_q, l2_q, vo_q, lo_q;
  logic [AW-1:0]           ph1_q;
  logic [DATA_WIDTH-1:0]   sc1_q, sc2_q;
  logic signed [DATA_WIDTH-1:0] sin2_q, cos2_q, sin_c, cos_c;
  logic [DATA_WIDTH-1:0]   itx_q, qtx_q;
  logic                    en, issue, last_cnt;
  logic [AW-1:0]           pc;

  assign en       = !vo_q || m_axis.tready;
  assign issue    = (state_q == S_RUN) && en;
  assign last_cnt = (count_q == LAST_CNT);
  assign pc       = ph1_q + AW'(LUT_N);

  always_comb begin
    sin_c = lookup(ph1_q);
    cos_c = lookup(pc);
  end

  // Start is taken in IDLE even while the previous burst drains; scale travels with each sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= START_PH;
      count_q <= '0;
      gap_q   <= '0;
      inc_q   <= DPH_INC;
      scale_q <= SCALE_MAX;
    end else if (srst_i) begin
      state_q <= S_IDLE;
      phase_q <= START_PH;
      count_q <= '0;
      gap_q   <= '0;
      inc_q   <= DPH_INC;
      scale_q <= SCALE_MAX;
    end else begin
      case (state_q)
        S_IDLE: if (start_i) begin
          inc_q   <= (ppm_val_i == '0) ? DPH_INC : ppm_val_i[PHASE_WIDTH-1:0];
          scale_q <= (scale_val_i == '0) ? SCALE_MAX : scale_val_i;
          phase_q <= START_PH;
          count_q <= '0;
          state_q <= S_RUN;
        end
        S_RUN: if (en) begin
          phase_q <= phase_q + inc_q;
          count_q <= count_q + 1'b1;
          if (last_cnt) begin
            if (!continuous_i) begin
              state_q <= S_IDLE;
            end else if (GAP > 0) begin
              state_q <= S_GAP;
              gap_q   <= GAP_W'(GAP - 1);
            end else begin
              phase_q <= START_PH;
              count_q <= '0;
            end
          end
        end
        S_GAP: if (en) begin
          if (gap_q == '0) begin
            state_q <= S_RUN;
            phase_q <= START_PH;
            count_q <= '0;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {v1_q, l1_q, v2_q, l2_q, vo_q, lo_q} <= '0;
      ph1_q  <= '0;
      sc1_q  <= '0;
      sc2_q  <= '0;
      sin2_q <= '0;
      cos2_q <= '0;
      itx_q  <= '0;
      qtx_q  <= '0;
    end else if (srst_i) begin
      {v1_q, l1_q, v2_q, l2_q, vo_q, lo_q} <= '0;
      ph1_q  <= '0;
      sc1_q  <= '0;
      sc2_q  <= '0;
      sin2_q <= '0;
      cos2_q <= '0;
      itx_q  <= '0;
      qtx_q  <= '0;
    end else if (en) begin
      v1_q <= issue;
      l1_q <= issue && last_cnt;
      if (issue) begin
        ph1_q <= phase_q[PHASE_WIDTH-1 -: AW];
        sc1_q <= scale_q;
      end
      v2_q   <= v1_q;
      l2_q   <= l1_q;
      sc2_q  <= sc1_q;
      sin2_q <= sin_c;
      cos2_q <= cos_c;
      vo_q   <= v2_q;
      lo_q   <= l2_q;
      itx_q  <= scale_mul(cos2_q, sc2_q);
      qtx_q  <= scale_mul(sin2_q, sc2_q);
    end
  end

  assign m_axis.tvalid = vo_q;
  assign m_axis.tlast  = lo_q;
  assign m_axis.itx    = itx_q;
  assign m_axis.qtx    = qtx_q;
  assign busy_o        = (state_q != S_IDLE) || v1_q || v2_q || vo_q;
  assign ph_o          = phase_q;
  assign sig_n_o       = count_q;
endmodule
